pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Pipeline hazard controller that drives the stall and flush inputs of the fetch, decode, execute and memory pipeline registers. It observes the decode-stage source registers, the execute-register outputs, branch resolution and the cache stall lines. It resolves load-use, mispredict, ecall/trap and cache-miss hazards through a small state machine. It is the control-side counterpart of the execute pipeline register, producing the `i_stall_exec`/`i_flush_exec` that register consumes.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width
- CNT_WIDTH, 32, stall counter width

Ports:
- i_clk  in  1  clock
- i_arst  in  1  reset, synchronous, active-high
- i_rs1_addr_dec  in  REG_ADDR_W  rs1 of the instruction in decode
- i_rs2_addr_dec  in  REG_ADDR_W  rs2 of the instruction in decode
- i_rd_addr_exec  in  REG_ADDR_W  rd from the execute register output
- i_reg_we_exec  in  1  reg write enable from the execute register output
- i_load_instr_exec  in  1  load flag from the execute register output
- i_mispredict_exec  in  1  branch/jump resolved against its prediction
- i_ecall_exec  in  1  ecall in execute
- i_icache_stall  in  1  instruction fetch miss in progress
- i_dcache_stall  in  1  memory-stage miss in progress
- i_trap_done  in  1  trap unit accepted redirect (1-cycle pulse)
- o_stall_fetch, o_stall_dec, o_stall_exec, o_stall_mem  out  1 each  pipeline register stalls
- o_flush_dec, o_flush_exec  out  1 each  pipeline register flushes
- o_trap_req  out  1  registered trap request level
- o_stall_cnt  out  CNT_WIDTH  decode-stall cycle count

## Operation
- States: RUN, MEM_WAIT, TRAP_WAIT. Reset state is RUN.
- Load-use hazard (lu): i_load_instr_exec & i_reg_we_exec & (i_rd_addr_exec != 0) & (rd == rs1_dec | rd == rs2_dec).
- RUN priority, highest first:
  - i_dcache_stall: all four stalls = 1, no flush; next state MEM_WAIT.
  - i_ecall_exec: flush_dec = flush_exec = 1, stall_fetch = 1; next state TRAP_WAIT.
  - i_mispredict_exec: flush_dec = flush_exec = 1, stall_fetch = i_icache_stall; stay in RUN.
  - lu: stall_fetch = stall_dec = 1, flush_exec = 1 (one bubble); stay in RUN.
  - i_icache_stall: stall_fetch = 1, flush_dec = 1 (bubble into decode); stay in RUN.
  - Otherwise all outputs 0.
- MEM_WAIT:
  - While i_dcache_stall = 1: all four stalls = 1. Ecall, mispredict and lu are ignored because the execute contents are frozen.
  - In the cycle i_dcache_stall = 0: apply the RUN rules combinationally in that same cycle; next state follows those rules.
- TRAP_WAIT:
  - stall_fetch = stall_dec = 1, flush_exec = 1, stall_mem = i_dcache_stall. Older instructions drain.
  - i_trap_done & ~i_dcache_stall: stall_fetch = 0, flush_dec = flush_exec = 1; next state RUN.
  - i_trap_done while i_dcache_stall = 1 is ignored; the trap unit must re-pulse.
- Stall and flush are never both asserted for the same register except flush_exec during lu or TRAP_WAIT, where flush wins at the register.

## Timing
- Stall and flush outputs are combinational from state and inputs: zero latency.
- o_trap_req is a flop: 1 on the cycle after entering TRAP_WAIT, held until the edge that leaves TRAP_WAIT.
- State and o_trap_req update on the rising edge of i_clk.
- While i_arst = 1 all outputs are 0. On the edge that samples i_arst = 1: state → RUN, o_trap_req → 0, o_stall_cnt → 0.
- Reset mid-MEM_WAIT or mid-TRAP_WAIT: controller is in RUN on the next cycle with no residual request.
- Simultaneous events: only the highest-priority event is acted on. A lower-priority event still present next cycle is handled then.

## Configuration
- PIPE_HAZARD_STALL_CNT_EN defined:
  - o_stall_cnt increments by 1 on every edge where o_stall_dec = 1 and i_arst = 0.
  - Wraps from all-ones to 0.
- Macro undefined: o_stall_cnt is constant 0 and no counter flops are built.

## Test plan
- Load-use: exec load rd=5, reg_we=1, decode rs2=5 → one cycle of stall_fetch=stall_dec=flush_exec=1; next cycle all 0. Same case with rd=0 → no stall.
- D-cache miss: i_dcache_stall high for 4 cycles → all stalls 1 for exactly 4 cycles. A mispredict during those cycles is ignored, then acted on in the release cycle if still asserted.
- Ecall: i_ecall_exec for 1 cycle → flush_dec=flush_exec=1 that cycle; o_trap_req=1 from the next cycle. i_trap_done after 3 cycles → flushes, RUN, o_trap_req=0 next cycle.
- Priority: i_dcache_stall, i_ecall_exec and lu all asserted together → only the four stalls, no flush, state MEM_WAIT.
- Reset in TRAP_WAIT: i_arst pulsed 1 cycle → all outputs 0 during reset; RUN, o_trap_req=0 and (with PIPE_HAZARD_STALL_CNT_EN) o_stall_cnt=0 after.
- Counter (PIPE_HAZARD_STALL_CNT_EN, CNT_WIDTH=4): 17 decode-stall cycles → o_stall_cnt=1 (wrapped).

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation for fetch, decode, execute and memory registers.
// Optional decode-stall counter is built only when PIPE_HAZARD_STALL_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr_dec,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr_dec,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_exec,
    input  logic                  i_reg_we_exec,
    input  logic                  i_load_instr_exec,
    input  logic                  i_mispredict_exec,
    input  logic                  i_ecall_exec,
    input  logic                  i_icache_stall,
    input  logic                  i_dcache_stall,
    input  logic                  i_trap_done,
    output logic                  o_stall_fetch,
    output logic                  o_stall_dec,
    output logic                  o_stall_exec,
    output logic                  o_stall_mem,
    output logic                  o_flush_dec,
    output logic                  o_flush_exec,
    output logic                  o_trap_req,
    output logic [CNT_WIDTH-1:0]  o_stall_cnt
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        TRAP_WAIT = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   trap_req_q, trap_req_d;
    logic   load_use;
    logic   run_rules;

    assign load_use = i_load_instr_exec & i_reg_we_exec & (i_rd_addr_exec != '0) &
                      ((i_rd_addr_exec == i_rs1_addr_dec) | (i_rd_addr_exec == i_rs2_addr_dec));

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        run_rules     = 1'b0;
        o_stall_fetch = 1'b0;
        o_stall_dec   = 1'b0;
        o_stall_exec  = 1'b0;
        o_stall_mem   = 1'b0;
        o_flush_dec   = 1'b0;
        o_flush_exec  = 1'b0;

        case (state_q)
            RUN: run_rules = 1'b1;
            MEM_WAIT: begin
                if (i_dcache_stall) begin
                    o_stall_fetch = 1'b1;
                    o_stall_dec   = 1'b1;
                    o_stall_exec  = 1'b1;
                    o_stall_mem   = 1'b1;
                end else begin
                    run_rules = 1'b1;
                end
            end
            TRAP_WAIT: begin
                if (i_trap_done && !i_dcache_stall) begin
                    o_flush_dec  = 1'b1;
                    o_flush_exec = 1'b1;
                    state_d      = RUN;
                end else begin
                    o_stall_fetch = 1'b1;
                    o_stall_dec   = 1'b1;
                    o_flush_exec  = 1'b1;
                    o_stall_mem   = i_dcache_stall;
                end
            end
            default: state_d = RUN;
        endcase

        // Release from MEM_WAIT reuses the RUN priority chain in the same cycle.
        if (run_rules) begin
            state_d = RUN;
            if (i_dcache_stall) begin
                o_stall_fetch = 1'b1;
                o_stall_dec   = 1'b1;
                o_stall_exec  = 1'b1;
                o_stall_mem   = 1'b1;
                state_d       = MEM_WAIT;
            end else if (i_ecall_exec) begin
                o_stall_fetch = 1'b1;
                o_flush_dec   = 1'b1;
                o_flush_exec  = 1'b1;
                state_d       = TRAP_WAIT;
            end else if (i_mispredict_exec) begin
                o_stall_fetch = i_icache_stall;
                o_flush_dec   = 1'b1;
                o_flush_exec  = 1'b1;
            end else if (load_use) begin
                o_stall_fetch = 1'b1;
                o_stall_dec   = 1'b1;
                o_flush_exec  = 1'b1;
            end else if (i_icache_stall) begin
                o_stall_fetch = 1'b1;
                o_flush_dec   = 1'b1;
            end
        end

        if (i_arst) begin
            o_stall_fetch = 1'b0;
            o_stall_dec   = 1'b0;
            o_stall_exec  = 1'b0;
            o_stall_mem   = 1'b0;
            o_flush_dec   = 1'b0;
            o_flush_exec  = 1'b0;
        end
    end

    assign trap_req_d = (state_d == TRAP_WAIT);

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (i_arst) begin
            state_q    <= RUN;
            trap_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            trap_req_q <= trap_req_d;
        end
    end

    assign o_trap_req = trap_req_q & ~i_arst;

`ifdef PIPE_HAZARD_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = o_stall_dec ? stall_cnt_q + CNT_WIDTH'(1) : stall_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_arst) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign o_stall_cnt = i_arst ? '0 : stall_cnt_q;
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table plus multi-cycle sequences,
// expectations queued at drive time and compared on the falling edge.
module tb_pipeline_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;

    // Flag order: {stall_fetch, stall_dec, stall_exec, stall_mem, flush_dec, flush_exec}
    localparam logic [5:0] NONE  = 6'b000000;
    localparam logic [5:0] ALLST = 6'b111100;
    localparam logic [5:0] LU    = 6'b110001;
    localparam logic [5:0] IC    = 6'b100010;
    localparam logic [5:0] MISP  = 6'b000011;
    localparam logic [5:0] MISPI = 6'b100011;
    localparam logic [5:0] ECALL = 6'b100011;
    localparam logic [5:0] TRAPW = 6'b110001;
    localparam logic [5:0] TRAPD = 6'b110101;
    localparam logic [5:0] TREL  = 6'b000011;

    logic          i_clk;
    logic          i_arst;
    logic [AW-1:0] i_rs1_addr_dec, i_rs2_addr_dec, i_rd_addr_exec;
    logic          i_reg_we_exec, i_load_instr_exec, i_mispredict_exec, i_ecall_exec;
    logic          i_icache_stall, i_dcache_stall, i_trap_done;
    logic          o_stall_fetch, o_stall_dec, o_stall_exec, o_stall_mem;
    logic          o_flush_dec, o_flush_exec, o_trap_req;
    logic [CW-1:0] o_stall_cnt;

    pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_WIDTH(CW)) dut (
        .i_clk             (i_clk),
        .i_arst            (i_arst),
        .i_rs1_addr_dec    (i_rs1_addr_dec),
        .i_rs2_addr_dec    (i_rs2_addr_dec),
        .i_rd_addr_exec    (i_rd_addr_exec),
        .i_reg_we_exec     (i_reg_we_exec),
        .i_load_instr_exec (i_load_instr_exec),
        .i_mispredict_exec (i_mispredict_exec),
        .i_ecall_exec      (i_ecall_exec),
        .i_icache_stall    (i_icache_stall),
        .i_dcache_stall    (i_dcache_stall),
        .i_trap_done       (i_trap_done),
        .o_stall_fetch     (o_stall_fetch),
        .o_stall_dec       (o_stall_dec),
        .o_stall_exec      (o_stall_exec),
        .o_stall_mem       (o_stall_mem),
        .o_flush_dec       (o_flush_dec),
        .o_flush_exec      (o_flush_exec),
        .o_trap_req        (o_trap_req),
        .o_stall_cnt       (o_stall_cnt)
    );

    typedef struct packed {
        logic          arst;
        logic [AW-1:0] rs1, rs2, rd;
        logic          we, ld, misp, ecall, ic, dc, tdone;
        logic [5:0]    flags;
        logic          trap;
    } vec_t;

    typedef struct {
        logic [5:0]    flags;
        logic          trap;
        logic [CW-1:0] cnt;
        int            idx;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_cmp = 0;
    int            n_fail = 0;
    int            step_idx = 0;
    logic [CW-1:0] cnt_model = '0;
    vec_t          tbl[13];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic vec_t mk(input logic arst, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                input logic [AW-1:0] rd, input logic we, input logic ld,
                                input logic misp, input logic ecall, input logic ic, input logic dc,
                                input logic tdone, input logic [5:0] flags, input logic trap);
        vec_t v;
        v.arst = arst; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.we = we; v.ld = ld;
        v.misp = misp; v.ecall = ecall; v.ic = ic; v.dc = dc; v.tdone = tdone;
        v.flags = flags; v.trap = trap;
        return v;
    endfunction

    task automatic step(input vec_t v);
        exp_t e;
        i_arst = v.arst; i_rs1_addr_dec = v.rs1; i_rs2_addr_dec = v.rs2; i_rd_addr_exec = v.rd;
        i_reg_we_exec = v.we; i_load_instr_exec = v.ld; i_mispredict_exec = v.misp;
        i_ecall_exec = v.ecall; i_icache_stall = v.ic; i_dcache_stall = v.dc; i_trap_done = v.tdone;
        e.flags = v.flags;
        e.trap  = v.trap;
`ifdef PIPE_HAZARD_STALL_CNT_EN
        e.cnt   = v.arst ? '0 : cnt_model;
`else
        e.cnt   = '0;
`endif
        e.idx   = step_idx;
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        if (v.arst)          cnt_model = '0;
        else if (v.flags[4]) cnt_model = cnt_model + 1'b1;
        step_idx++;
    endtask

    always @(negedge i_clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check($sformatf("step%0d flags", mon_e.idx),
                  {26'd0, o_stall_fetch, o_stall_dec, o_stall_exec, o_stall_mem, o_flush_dec, o_flush_exec},
                  {26'd0, mon_e.flags});
            check($sformatf("step%0d trap_req", mon_e.idx), {31'd0, o_trap_req}, {31'd0, mon_e.trap});
            check($sformatf("step%0d stall_cnt", mon_e.idx), {28'd0, o_stall_cnt}, {28'd0, mon_e.cnt});
        end
    end

    initial begin
        tbl[0]  = mk(0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, NONE,  0);
        tbl[1]  = mk(0, 3, 5, 5, 1, 1, 0, 0, 0, 0, 0, LU,    0);
        tbl[2]  = mk(0, 7, 2, 7, 1, 1, 0, 0, 0, 0, 0, LU,    0);
        tbl[3]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, NONE,  0);
        tbl[4]  = mk(0, 5, 5, 5, 0, 1, 0, 0, 0, 0, 0, NONE,  0);
        tbl[5]  = mk(0, 5, 5, 5, 1, 0, 0, 0, 0, 0, 0, NONE,  0);
        tbl[6]  = mk(0, 4, 6, 5, 1, 1, 0, 0, 0, 0, 0, NONE,  0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, IC,    0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, MISP,  0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, MISPI, 0);
        tbl[10] = mk(0, 5, 5, 5, 1, 1, 1, 0, 0, 0, 0, MISP,  0);
        tbl[11] = mk(0, 5, 1, 5, 1, 1, 0, 0, 1, 0, 0, LU,    0);
        tbl[12] = mk(0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, NONE,  0);

        i_arst = 1'b1; i_rs1_addr_dec = '0; i_rs2_addr_dec = '0; i_rd_addr_exec = '0;
        i_reg_we_exec = 1'b0; i_load_instr_exec = 1'b0; i_mispredict_exec = 1'b0;
        i_ecall_exec = 1'b0; i_icache_stall = 1'b0; i_dcache_stall = 1'b0; i_trap_done = 1'b0;
        @(posedge i_clk);
        #1;

        // Reset with hazards present: everything held at 0.
        step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, NONE, 0));

        for (int i = 0; i < 13; i++) step(tbl[i]);

        // D-cache miss for 4 cycles; mispredict and load-use ignored, mispredict taken on release.
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ALLST, 0));
        for (int i = 0; i < 3; i++) step(mk(0, 5, 5, 5, 1, 1, 1, 0, 0, 1, 0, ALLST, 0));
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, MISP, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));

        // Priority: dcache + ecall + lu -> stalls only; ecall taken on release.
        step(mk(0, 5, 5, 5, 1, 1, 0, 1, 0, 1, 0, ALLST, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, ECALL, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, TRAPW, 1));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, TREL,  1));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE,  0));

        // Ecall with trap_done ignored under a d-cache stall, then accepted.
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, ECALL, 0));
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, TRAPW, 1));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, TRAPD, 1));
        step(mk(0, 5, 5, 5, 1, 1, 0, 0, 0, 0, 0, TRAPW, 1));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, TREL,  1));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE,  0));

        // Reset in TRAP_WAIT: back to RUN with no residual request.
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, ECALL, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, TRAPW, 1));
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE,  0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE,  0));

        // 17 decode-stall cycles wrap a 4-bit counter to 1.
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
        for (int i = 0; i < 17; i++) step(mk(0, 9, 0, 9, 1, 1, 0, 0, 0, 0, 0, LU, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
`ifdef PIPE_HAZARD_STALL_CNT_EN
        check("cnt_wrap", {28'd0, o_stall_cnt}, 32'd1);
`else
        check("cnt_wrap", {28'd0, o_stall_cnt}, 32'd0);
`endif

        @(negedge i_clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
